ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Sequences the configuration-chain (CCFF) programming of a logical tile such as a fractured LUT6 tile (64 LUT SRAM bits + 2 mode bits per LUT).
- Accepts a bitstream as WORD_W-bit words over a valid/ready interface and serialises it MSB-first onto ccff_head.
- Drives config_enable for exactly one cycle per shifted bit and reports busy/done/error.
- Sits between the bitstream source and the head of the tile's chain; the chain tail returns for optional readback.

Parameters:
- CHAIN_LEN, 66, total configuration bits in the chain; legal range 1..65535.
- WORD_W, 8, bitstream word width in bits; legal range 1..32.
- CNT_W, 16, width of the shifted-bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clock  input  1  programming clock; the loader and the chain both use it.
- prog_reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin loading; honoured only in IDLE.
- abort  input  1  cancels an operation in progress.
- bs_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- bs_valid  input  1  bs_data is valid.
- bs_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial data into the chain head.
- config_enable  output  1  chain shift enable; the chain shifts on each prog_clock edge while this is high.
- ccff_tail  input  1  serial data out of the chain tail.
- busy  output  1  high in any state other than IDLE and DONE.
- done  output  1  load complete; level signal.
- error  output  1  readback mismatch; sticky.

Behaviour:
- Clock and reset: one clock, prog_clock. prog_reset is asynchronous and active-high.
- Reset values: all outputs 0. State is IDLE and all counters are 0. Chain contents after reset are undefined and are not the loader's concern.
- Output timing: all outputs are registered. ccff_head and config_enable update together, and the chain captures ccff_head on the following edge.
- States: IDLE, FETCH, SHIFT, VERIFY (only with the optional feature), DONE.
- IDLE / DONE to FETCH:
  - On start, clear done, error and the bit counter, then go to FETCH.
  - start is ignored in FETCH, SHIFT and VERIFY.
- FETCH:
  - bs_ready=1, config_enable=0.
  - On bs_valid&&bs_ready, latch bs_data into the shift buffer, set bit_idx=WORD_W-1, and go to SHIFT on the next cycle.
  - bs_ready drops in the cycle after the transfer.
- SHIFT:
  - Each cycle: ccff_head=buffer[bit_idx], config_enable=1, and increment the bit counter.
  - Word exhausted with bits remaining: return to FETCH. There is no prefetch, so config_enable is low for at least one cycle between words; the chain holds its contents.
  - Bit counter reaches CHAIN_LEN: stop immediately, even mid-word. The unused LSBs of the final word are discarded. Go to VERIFY if the feature is compiled in, otherwise to DONE.
- Word count: exactly ceil(CHAIN_LEN/WORD_W) words are consumed. config_enable is high for exactly CHAIN_LEN cycles per load.
- DONE: done=1, busy=0, config_enable=0, bs_ready=0. The state is held until the next start.
- abort:
  - In FETCH, SHIFT or VERIFY, go to IDLE on the next edge. config_enable, bs_ready and busy are 0 from that edge.
  - done stays 0. A word offered in the same cycle as abort is not accepted (abort has priority over the handshake).
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-operation: the asynchronous return to IDLE drops config_enable immediately. The partially shifted chain is left as-is.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- With the macro defined:
  - During SHIFT the loader keeps a running XOR parity of every bit driven on ccff_head.
  - VERIFY then recirculates the chain for CHAIN_LEN cycles: ccff_head=ccff_tail, config_enable=1, restoring the original contents. It accumulates the XOR of the sampled ccff_tail bits.
  - At the end of VERIFY, parity mismatch sets error=1; the state goes to DONE either way.
  - Total config_enable-high cycles per load are 2*CHAIN_LEN.
- Without the macro: VERIFY, the parity logic and its registers are absent; ccff_tail is unused and error is tied to 0.

Test Plan:
1. CHAIN_LEN=66, WORD_W=8; start, then 9 words 0xA5,0x3C,…,0xC0 back-to-back with bs_valid held → exactly 9 handshakes; exactly 66 config_enable-high cycles; a 66-bit bench shift model equals the concatenated stream truncated to 66 bits (the final word contributes bits 7:6); done=1, busy=0.
2. Source stalls: bs_valid low 5 cycles before each word → config_enable stays low during stalls, bit count and final chain image identical to scenario 1.
3. Assert abort after 20 shifted bits → next edge: config_enable=0, busy=0, done=0, bs_ready=0; a new start with a fresh stream completes correctly.
4. prog_reset pulsed mid-SHIFT, asynchronously to the clock edge → all outputs 0 immediately; start after release performs a full, correct 66-bit load.
5. start pulsed while busy, and start with abort in IDLE → the start while busy is ignored with no extra shifts; start wins in IDLE.
6. CCFF_READBACK_EN defined → 132 config_enable-high cycles, chain image unchanged after VERIFY, error=0. With a bench fault flipping one tail bit during VERIFY → error=1 and done=1.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a word-oriented bitstream MSB-first into a logic tile's CCFF chain.
// Define CCFF_READBACK_EN to add a recirculating parity readback (VERIFY state, error flag).
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 66,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clock,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
`ifdef CCFF_READBACK_EN
        ST_VERIFY = 3'd3,
`endif
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef CCFF_READBACK_EN
    logic error_q, error_d;
    logic spar_q, spar_d;
    logic tpar_q, tpar_d;
    logic phase_q, phase_d;

    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction
`endif

    // Next-state and next-output logic; outputs are registered versions of these _d values.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        en_d    = 1'b0;
        done_d  = done_q;
`ifdef CCFF_READBACK_EN
        error_d = error_q;
        spar_d  = spar_q;
        tpar_d  = tpar_q;
        phase_d = phase_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cnt_d   = {CNT_W{1'b0}};
                    done_d  = 1'b0;
`ifdef CCFF_READBACK_EN
                    error_d = 1'b0;
                    spar_d  = 1'b0;
                    tpar_d  = 1'b0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bs_valid && ready_q) begin
                    // The first bit of the word goes out in the first SHIFT cycle.
                    state_d = ST_SHIFT;
                    buf_d   = bs_data;
                    idx_d   = TOP_IDX;
                    head_d  = bs_data[WORD_W-1];
                    en_d    = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                    spar_d  = parity_step(spar_q, bs_data[WORD_W-1]);
`endif
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_CNT) begin
`ifdef CCFF_READBACK_EN
                    state_d = ST_VERIFY;
                    cnt_d   = {CNT_W{1'b0}};
                    phase_d = 1'b0;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`endif
                end else if (idx_q == {IDX_W{1'b0}}) begin
                    state_d = ST_FETCH;
                end else begin
                    idx_d  = idx_q - IDX_W'(1);
                    head_d = buf_q[idx_q - IDX_W'(1)];
                    en_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                    spar_d = parity_step(spar_q, buf_q[idx_q - IDX_W'(1)]);
`endif
                end
            end
`ifdef CCFF_READBACK_EN
            ST_VERIFY: begin
                // Head is registered, so sample the tail only while the chain is still,
                // then spend one cycle shifting it back in.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!phase_q) begin
                    head_d  = ccff_tail;
                    en_d    = 1'b1;
                    tpar_d  = parity_step(tpar_q, ccff_tail);
                    cnt_d   = cnt_q + CNT_W'(1);
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        error_d = tpar_q ^ spar_q;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_FETCH);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge prog_clock or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= ST_IDLE;
            buf_q   <= {WORD_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CCFF_READBACK_EN
    // Readback parity accumulators and the sticky error flag.
    always_ff @(posedge prog_clock or posedge prog_reset) begin
        if (prog_reset) begin
            error_q <= 1'b0;
            spar_q  <= 1'b0;
            tpar_q  <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            error_q <= error_d;
            spar_q  <= spar_d;
            tpar_q  <= tpar_d;
            phase_q <= phase_d;
        end
    end

    assign error = error_q;
`else
    logic unused_tail_s;
    assign unused_tail_s = ccff_tail;
    assign error         = 1'b0;
`endif

    assign bs_ready      = ready_q;
    assign ccff_head     = head_q;
    assign config_enable = en_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: random bitstreams into a behavioural CCFF chain, image and count checks.
module tb_ccff_chain_loader;

    localparam int L  = 66;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;
`ifdef CCFF_READBACK_EN
    localparam int EN_PER_LOAD = 2 * L;
`else
    localparam int EN_PER_LOAD = L;
`endif

    logic         prog_clock = 1'b0;
    logic         prog_reset = 1'b1;
    logic         start      = 1'b0;
    logic         abort      = 1'b0;
    logic [W-1:0] bs_data    = '0;
    logic         bs_valid   = 1'b0;
    logic         bs_ready;
    logic         ccff_head;
    logic         config_enable;
    logic         ccff_tail;
    logic         busy;
    logic         done;
    logic         error;

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(16)) dut (
        .prog_clock   (prog_clock),
        .prog_reset   (prog_reset),
        .start        (start),
        .abort        (abort),
        .bs_data      (bs_data),
        .bs_valid     (bs_valid),
        .bs_ready     (bs_ready),
        .ccff_head    (ccff_head),
        .config_enable(config_enable),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 prog_clock = ~prog_clock;

    // Behavioural chain: shifts ccff_head in at the head on every enabled edge.
    logic [L-1:0] chain_m   = '0;
    int           en_cnt    = 0;
    int           hs_cnt    = 0;
    bit           fault_arm = 1'b0;
    int           fault_at  = 0;
    int           en_base   = 0;
    int           hs_base   = 0;
    bit           kill_src  = 1'b0;
    int           n_checks  = 0;
    int           n_errors  = 0;
    logic [W-1:0] words [NW];

    always @(posedge prog_clock) begin
        if (bs_valid && bs_ready && !abort) hs_cnt <= hs_cnt + 1;
        if (config_enable) begin
            en_cnt <= en_cnt + 1;
            if (fault_arm && (en_cnt + 1 == fault_at))
                chain_m <= {~chain_m[L-2], chain_m[L-3:0], ccff_head};
            else
                chain_m <= {chain_m[L-2:0], ccff_head};
        end
    end

    assign ccff_tail = chain_m[L-1];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream bit k (k=0 first) lands at chain position L-1-k after L shifts.
    function automatic logic [L-1:0] image_of();
        logic [L-1:0] img;
        img = '0;
        for (int k = 0; k < L; k++) img[L-1-k] = words[k / W][W-1-(k % W)];
        return img;
    endfunction

    task automatic fill_words(input bit fixed);
        logic [W-1:0] fixed_tbl [NW];
        fixed_tbl = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'hF0, 8'h5A, 8'hC3, 8'h69, 8'hC0};
        for (int i = 0; i < NW; i++) words[i] = fixed ? fixed_tbl[i] : W'($urandom);
    endtask

    // Offers the words in order; optional stalls, abort after abort_at shifted bits.
    task automatic send_stream(input int stall_lo, input int stall_hi, input int abort_at);
        int t;
        for (int i = 0; i < NW; i++) begin
            bs_valid = 1'b0;
            repeat (int'($urandom_range(stall_hi, stall_lo))) begin
                @(negedge prog_clock);
                if (bs_ready) check_eq("en_low_in_stall", 128'(config_enable), 128'(0));
            end
            bs_valid = 1'b1;
            bs_data  = words[i];
            t = 0;
            while (!bs_ready && t < 400) begin
                if (kill_src) begin
                    bs_valid = 1'b0;
                    return;
                end
                if (abort_at > 0 && (en_cnt - en_base) >= abort_at) begin
                    abort = 1'b1;
                    @(negedge prog_clock);
                    abort    = 1'b0;
                    bs_valid = 1'b0;
                    return;
                end
                @(negedge prog_clock);
                t++;
            end
            if (t >= 400) begin
                check_eq("ready_wait", 128'(t), 128'(0));
                bs_valid = 1'b0;
                return;
            end
            @(negedge prog_clock);
        end
        bs_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 3000) begin
            @(negedge prog_clock);
            t++;
        end
        if (!done) check_eq("done_wait", 128'(done), 128'(1));
    endtask

    task automatic run_load(input int stall_lo, input int stall_hi, input bit poke_start,
                            input bit with_abort, input bit inject_fault);
        logic [L-1:0] exp_img;
        exp_img = image_of();
        en_base = en_cnt;
        hs_base = hs_cnt;
        if (inject_fault) begin
            fault_at  = en_base + L;
            fault_arm = 1'b1;
            exp_img[L-1] = ~exp_img[L-1];
        end
        start = 1'b1;
        abort = with_abort;
        @(negedge prog_clock);
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_state", 128'({busy, done, error, bs_ready}), 128'(4'b1001));
        fork
            send_stream(stall_lo, stall_hi, 0);
            begin
                if (poke_start) begin
                    repeat (12) @(negedge prog_clock);
                    start = 1'b1;
                    @(negedge prog_clock);
                    start = 1'b0;
                end
            end
        join
        wait_done();
        fault_arm = 1'b0;
        check_eq("handshakes", 128'(hs_cnt - hs_base), 128'(NW));
        check_eq("enable_cycles", 128'(en_cnt - en_base), 128'(EN_PER_LOAD));
        check_eq("chain_image", 128'(chain_m), 128'(exp_img));
        check_eq("done_outs", 128'({busy, done, bs_ready, config_enable}), 128'(4'b0100));
        check_eq("error_flag", 128'(error), 128'(inject_fault));
        repeat (3) @(negedge prog_clock);
        check_eq("done_hold", 128'({done, en_cnt - en_base}), 128'({1'b1, EN_PER_LOAD}));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge prog_clock);
        check_eq("reset_outs", 128'({busy, done, error, bs_ready, config_enable, ccff_head}), 128'(0));
        prog_reset = 1'b0;
        @(negedge prog_clock);
        check_eq("idle_outs", 128'({busy, done, error, bs_ready, config_enable}), 128'(0));

        // Fixed stream, back-to-back words
        fill_words(1'b1);
        run_load(0, 0, 1'b0, 1'b0, 1'b0);

        // Source stalls before each word
        fill_words(1'b0);
        run_load(5, 12, 1'b0, 1'b0, 1'b0);

        // Abort after 20 shifted bits
        fill_words(1'b0);
        en_base = en_cnt;
        hs_base = hs_cnt;
        start = 1'b1;
        @(negedge prog_clock);
        start = 1'b0;
        send_stream(0, 0, 20);
        check_eq("abort_outs", 128'({config_enable, busy, done, bs_ready}), 128'(0));
        check_eq("abort_words", 128'(hs_cnt - hs_base), 128'(3));

        // Abort in FETCH beats a word offered in the same cycle
        start = 1'b1;
        @(negedge prog_clock);
        start    = 1'b0;
        bs_data  = 8'hFF;
        bs_valid = 1'b1;
        abort    = 1'b1;
        en_base  = en_cnt;
        @(negedge prog_clock);
        abort    = 1'b0;
        bs_valid = 1'b0;
        check_eq("abort_fetch_outs", 128'({busy, bs_ready, done}), 128'(0));
        @(negedge prog_clock);
        check_eq("abort_fetch_noshift", 128'(en_cnt - en_base), 128'(0));
        fill_words(1'b0);
        run_load(0, 2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of SHIFT
        fill_words(1'b0);
        en_base = en_cnt;
        start = 1'b1;
        @(negedge prog_clock);
        start = 1'b0;
        fork
            send_stream(0, 0, 0);
            begin
                for (int t = 0; t < 500 && (en_cnt - en_base) < 30; t++) @(negedge prog_clock);
                #2 prog_reset = 1'b1;
                #1;
                check_eq("async_reset_outs",
                         128'({busy, done, error, bs_ready, config_enable, ccff_head}), 128'(0));
                @(negedge prog_clock);
                prog_reset = 1'b0;
                kill_src   = 1'b1;
            end
        join
        kill_src = 1'b0;
        @(negedge prog_clock);
        fill_words(1'b0);
        run_load(0, 3, 1'b0, 1'b0, 1'b0);

        // start pulsed while busy is ignored
        fill_words(1'b0);
        run_load(0, 3, 1'b1, 1'b0, 1'b0);

        // start together with abort in IDLE: start wins
        prog_reset = 1'b1;
        @(negedge prog_clock);
        prog_reset = 1'b0;
        @(negedge prog_clock);
        fill_words(1'b0);
        run_load(0, 0, 1'b0, 1'b1, 1'b0);

`ifdef CCFF_READBACK_EN
        // Corrupted tail bit during readback must raise error
        fill_words(1'b0);
        run_load(0, 2, 1'b0, 1'b0, 1'b1);
        fill_words(1'b0);
        run_load(0, 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
